fifo_rate_ctrl: RTL and testbench

//  Parametrised pointer/flow controller for the circular sample buffer. It generates the write and read

---
 rtl/fifo_ctrl_pkg.sv | 23 ++
 rtl/ring_ptr.sv | 27 ++
 rtl/fifo_rate_ctrl.sv | 144 ++++++++++++++
 tb/tb_fifo_rate_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the circular sample-buffer pointer/flow controller.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int unsigned DEF_AW        = 9;
  localparam int unsigned DEF_WSTEP_W   = 8;
  localparam int unsigned DEF_WSTEP_N   = 4;
  localparam int unsigned DEF_RSTEP     = 3;
  localparam int unsigned DEF_START_LVL = 128;
  localparam int unsigned DEF_HEADROOM  = 96;

  function automatic int unsigned step_sel(input logic narrow,
                                           input int unsigned wide_step   = DEF_WSTEP_W,
                                           input int unsigned narrow_step = DEF_WSTEP_N);
    return narrow ? narrow_step : wide_step;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Registered ring pointer; advances by step when en, wrapping modulo 2**AW.
module ring_ptr #(
  parameter int unsigned AW = 9
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          en,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q, ptr_d;

  // AW-bit add drops the carry, which is exactly the modulo-DEPTH wrap
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + step;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_rate_ctrl.sv
// Pointer/flow controller: burst writes, fixed-stride reads, priming, occupancy and error flags.
module fifo_rate_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned WSTEP_W   = DEF_WSTEP_W,
  parameter int unsigned WSTEP_N   = DEF_WSTEP_N,
  parameter int unsigned RSTEP     = DEF_RSTEP,
  parameter int unsigned START_LVL = DEF_START_LVL,
  parameter int unsigned HEADROOM  = DEF_HEADROOM
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr,
  input  logic          narrow,
  input  logic          rd_stall,
  input  logic          clr_err,
  output logic [AW-1:0] in_adr,
  output logic [AW-1:0] out_adr,
  output logic [AW:0]   fill,
  output logic          out_en,
  output logic          overflow,
  output logic          drop_err,
  output logic          underflow,
  output logic [1:0]    state
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0]   RSTEP_V = (AW+1)'(RSTEP);
  localparam logic [AW-1:0] RSTEP_P = AW'(RSTEP);
  localparam logic [AW:0]   START_V = (AW+1)'(START_LVL);
  localparam logic [AW:0]   OVF_LIM = (AW+1)'(DEPTH - HEADROOM);

  if (WSTEP_W < 1 || WSTEP_W > DEPTH - 1) begin : g_bad_wstep_w
    $error("WSTEP_W out of range 1..DEPTH-1");
  end
  if (WSTEP_N < 1 || WSTEP_N > DEPTH - 1) begin : g_bad_wstep_n
    $error("WSTEP_N out of range 1..DEPTH-1");
  end
  if (RSTEP < 1 || RSTEP > DEPTH - 1) begin : g_bad_rstep
    $error("RSTEP out of range 1..DEPTH-1");
  end
  if (START_LVL < RSTEP || START_LVL > DEPTH) begin : g_bad_start
    $error("START_LVL out of range RSTEP..DEPTH");
  end
  if (HEADROOM >= DEPTH) begin : g_bad_headroom
    $error("HEADROOM must be below DEPTH");
  end

  state_e      state_q, state_d;
  logic [AW:0] fill_q, fill_d;
  logic        ovf_q, ovf_d;
  logic        drop_q, drop_d;
  logic        und_q, und_d;
  logic        out_en_q, out_en_d;

  logic [AW:0] wstep;
  logic [AW:0] fill_w;
  logic        wa, ra;

  assign wstep  = (AW+1)'(step_sel(narrow, WSTEP_W, WSTEP_N));
  assign fill_w = fill_q + wstep;
  // space check sees only the registered fill; a same-cycle read frees nothing
  assign wa     = !wr && (fill_w <= DEPTH_V);
  assign ra     = (state_q == STREAM) && !rd_stall && (fill_q >= RSTEP_V);

  always_comb begin
    fill_d = fill_q;
    if (wa) fill_d = fill_d + wstep;
    if (ra) fill_d = fill_d - RSTEP_V;
  end

  always_comb begin
    drop_d = drop_q;
    if (clr_err)   drop_d = 1'b0;
    if (!wr && !wa) drop_d = 1'b1;
  end

  assign ovf_d = (fill_d > OVF_LIM);

  always_comb begin
    state_d = state_q;
    und_d   = 1'b0;
    unique case (state_q)
      IDLE:   if (wa) state_d = PRIME;
      PRIME:  if (fill_d >= START_V) state_d = STREAM;
      STREAM: begin
        if (fill_q < RSTEP_V && !rd_stall) begin
          if (fill_q == '0 && !wa) begin
            state_d = IDLE;
          end else begin
            state_d = PRIME;
            und_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_en_d = (state_d == STREAM);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      und_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      und_q    <= und_d;
      out_en_q <= out_en_d;
    end
  end

  ring_ptr #(.AW(AW)) u_wr_ptr (
    .Clk  (Clk),
    .Rst  (Rst),
    .en   (wa),
    .step (wstep[AW-1:0]),
    .ptr  (in_adr)
  );

  ring_ptr #(.AW(AW)) u_rd_ptr (
    .Clk  (Clk),
    .Rst  (Rst),
    .en   (ra),
    .step (RSTEP_P),
    .ptr  (out_adr)
  );

  assign fill      = fill_q;
  assign out_en    = out_en_q;
  assign overflow  = ovf_q;
  assign drop_err  = drop_q;
  assign underflow = und_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fifo_rate_ctrl.sv
// Randomized + directed bench for fifo_rate_ctrl against an occupancy-level model.
module tb_fifo_rate_ctrl;

  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int WW = 8, WN = 4, RS = 3, START = 128, HEAD = 96;

  logic          Clk, Rst;
  logic          wr, narrow, rd_stall, clr_err;
  logic [AW-1:0] in_adr, out_adr;
  logic [AW:0]   fill;
  logic          out_en, overflow, drop_err, underflow;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // reference model: plain integers
  int m_fill, m_in, m_out, m_st;
  bit m_ovf, m_drop, m_und;

  fifo_rate_ctrl dut (
    .Clk(Clk), .Rst(Rst), .wr(wr), .narrow(narrow), .rd_stall(rd_stall),
    .clr_err(clr_err), .in_adr(in_adr), .out_adr(out_adr), .fill(fill),
    .out_en(out_en), .overflow(overflow), .drop_err(drop_err),
    .underflow(underflow), .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_in = 0; m_out = 0; m_st = 0;
    m_ovf = 0; m_drop = 0; m_und = 0;
  endtask

  task automatic compare();
    chk("fill", int'(fill), m_fill);
    chk("in_adr", int'(in_adr), m_in);
    chk("out_adr", int'(out_adr), m_out);
    chk("state", int'(state), m_st);
    chk("out_en", int'(out_en), int'(m_st == 2));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_err", int'(drop_err), int'(m_drop));
    chk("underflow", int'(underflow), int'(m_und));
  endtask

  // apply one cycle of inputs, advance the model, compare after the edge
  task automatic cyc(input bit w, input bit n, input bit st, input bit c);
    int ws, nf;
    bit wa, ra;
    wr = w; narrow = n; rd_stall = st; clr_err = c;
    ws = n ? WN : WW;
    wa = !w && (m_fill + ws <= DEPTH);
    ra = (m_st == 2) && !st && (m_fill >= RS);
    nf = m_fill + (wa ? ws : 0) - (ra ? RS : 0);
    m_und = 0;
    case (m_st)
      0: if (wa) m_st = 1;
      1: if (nf >= START) m_st = 2;
      2: if (m_fill < RS && !st) begin
           if (m_fill == 0 && !wa) m_st = 0;
           else begin m_st = 1; m_und = 1; end
         end
      default: m_st = 0;
    endcase
    if (c) m_drop = 0;
    if (!w && !wa) m_drop = 1;
    if (wa) m_in = (m_in + ws) % DEPTH;
    if (ra) m_out = (m_out + RS) % DEPTH;
    m_fill = nf;
    m_ovf = (nf > DEPTH - HEAD);
    @(posedge Clk);
    #1;
    compare();
  endtask

  task automatic async_reset();
    #2 Rst = 1'b0;
    #1;
    model_reset();
    chk("rst_fill", int'(fill), 0);
    chk("rst_in", int'(in_adr), 0);
    chk("rst_out", int'(out_adr), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_flags", int'({out_en, overflow, drop_err, underflow}), 0);
    wr = 1; narrow = 0; rd_stall = 0; clr_err = 0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    Rst = 1'b0; wr = 1; narrow = 0; rd_stall = 0; clr_err = 0;
    model_reset();
    #12;
    compare();
    #10 Rst = 1'b1;

    // Scenario 1: 16 wide writes prime to 128, stream starts next cycle
    repeat (16) cyc(0, 0, 0, 0);
    chk("s1_fill", int'(fill), 128);
    chk("s1_state", int'(state), 2);
    chk("s1_out_en", int'(out_en), 1);
    chk("s1_in", int'(in_adr), 128);
    cyc(1, 0, 0, 0);
    chk("s1_out3", int'(out_adr), 3);
    chk("s1_fill125", int'(fill), 125);
    cyc(1, 0, 0, 0);
    chk("s1_out6", int'(out_adr), 6);

    // Scenario 2: write+read nets +5 per cycle, overflow above 416, in_adr wraps
    repeat (40) cyc(0, 0, 0, 0);
    chk("s2_fill322", int'(fill), 322);
    chk("s2_in448", int'(in_adr), 448);
    repeat (18) cyc(0, 0, 0, 0);
    chk("s2_fill412", int'(fill), 412);
    chk("s2_ovf0", int'(overflow), 0);
    cyc(0, 0, 0, 0);
    chk("s2_fill417", int'(fill), 417);
    chk("s2_ovf1", int'(overflow), 1);
    chk("s2_in_wrap", int'(in_adr), 88);

    // Scenario 3 + 5: stalled fill to 508, rejected wide, accepted narrow, clr/set priority
    async_reset();
    repeat (63) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("s3_fill508", int'(fill), 508);
    cyc(0, 0, 1, 0);
    chk("s3_drop", int'(drop_err), 1);
    chk("s3_fill_hold", int'(fill), 508);
    chk("s3_in_hold", int'(in_adr), 508);
    cyc(0, 1, 1, 0);
    chk("s3_fill512", int'(fill), 512);
    chk("s3_in0", int'(in_adr), 0);
    chk("s3_drop_sticky", int'(drop_err), 1);
    cyc(1, 0, 1, 1);
    chk("s3_clr", int'(drop_err), 0);
    cyc(0, 1, 1, 1);
    chk("s3_set_wins", int'(drop_err), 1);
    chk("s5_out_frozen", int'(out_adr), 0);
    chk("s3_ovf", int'(overflow), 1);

    // Scenario 4: drain from 128 to 2, then underflow pulse and back to PRIME
    async_reset();
    repeat (16) cyc(0, 0, 1, 0);
    repeat (41) cyc(1, 0, 0, 0);
    chk("s4_fill5", int'(fill), 5);
    cyc(1, 0, 0, 0);
    chk("s4_fill2", int'(fill), 2);
    chk("s4_still_stream", int'(state), 2);
    cyc(1, 0, 0, 0);
    chk("s4_und", int'(underflow), 1);
    chk("s4_prime", int'(state), 1);
    chk("s4_out_en0", int'(out_en), 0);
    cyc(1, 0, 0, 0);
    chk("s4_und_pulse", int'(underflow), 0);

    // Exact drain to zero falls back to IDLE without underflow
    async_reset();
    repeat (16) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    repeat (44) cyc(1, 0, 0, 0);
    chk("s6_fill0", int'(fill), 0);
    cyc(1, 0, 0, 0);
    chk("s6_idle", int'(state), 0);
    chk("s6_no_und", int'(underflow), 0);

    // Randomized: write-heavy then read-heavy, with occasional async reset
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        int wp;
        wp = (ph % 2 == 0) ? 70 : 25;
        cyc(($urandom_range(99) >= wp), $urandom_range(1), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0));
      end
      async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
